// File: rtl/reg_arb_pkg.sv
// Shared widths and requester indices for the register-file write arbiter.
package reg_arb_pkg;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 3;
   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the requester that did not win last
// time has priority when both ask.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       can_grant,
   output logic [1:0] gnt
);
   import reg_arb_pkg::*;

   always_comb begin
      gnt = 2'b00;
      if (can_grant) begin
         unique case (req)
            2'b01:   gnt[REQ_ALU] = 1'b1;
            2'b10:   gnt[REQ_MEM] = 1'b1;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end
endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback.
// Optional: REG_WR_ARB_R0_DISCARD_EN acks writes to R0 without loading the slot.
module reg_wr_arbiter
   import reg_arb_pkg::*;
#(
   parameter int DATA_W_P = DATA_W,
   parameter int ADDR_W_P = ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_req,
   input  logic [ADDR_W_P-1:0] alu_addr,
   input  logic [DATA_W_P-1:0] alu_data,
   output logic                alu_ack,
   input  logic                mem_req,
   input  logic [ADDR_W_P-1:0] mem_addr,
   input  logic [DATA_W_P-1:0] mem_data,
   output logic                mem_ack,
   input  logic                rf_stall,
   output logic                rf_wr_en,
   output logic [ADDR_W_P-1:0] rf_wr_addr,
   output logic [DATA_W_P-1:0] rf_wr_data,
   output logic                last_grant
);
   logic                en_q, en_d;
   logic [ADDR_W_P-1:0] addr_q, addr_d;
   logic [DATA_W_P-1:0] data_q, data_d;
   logic                last_q, last_d;
   logic                can_grant;
   logic [1:0]          gnt_raw, gnt;
   logic [ADDR_W_P-1:0] win_addr;
   logic [DATA_W_P-1:0] win_data;

   assign can_grant = !en_q || !rf_stall;

   rr_arb2 u_arb (
      .req        ({mem_req, alu_req}),
      .last_grant (last_q),
      .can_grant  (can_grant),
      .gnt        (gnt_raw)
   );

   // Reset is asynchronous, so an ack must not escape while it is held.
   assign gnt      = reset ? 2'b00 : gnt_raw;
   assign win_addr = gnt[REQ_MEM] ? mem_addr : alu_addr;
   assign win_data = gnt[REQ_MEM] ? mem_data : alu_data;

   always_comb begin
      en_d   = en_q;
      addr_d = addr_q;
      data_d = data_q;
      last_d = last_q;
      if (|gnt) begin
         last_d = gnt[REQ_MEM];
`ifdef REG_WR_ARB_R0_DISCARD_EN
         if (win_addr == '0) begin
            en_d = 1'b0;
         end else begin
            en_d   = 1'b1;
            addr_d = win_addr;
            data_d = win_data;
         end
`else
         en_d   = 1'b1;
         addr_d = win_addr;
         data_d = win_data;
`endif
      end else if (en_q && !rf_stall) begin
         en_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         last_q <= 1'b1;
      end else begin
         en_q   <= en_d;
         addr_q <= addr_d;
         data_q <= data_d;
         last_q <= last_d;
      end
   end

   assign alu_ack    = gnt[REQ_ALU];
   assign mem_ack    = gnt[REQ_MEM];
   assign rf_wr_en   = en_q;
   assign rf_wr_addr = addr_q;
   assign rf_wr_data = data_q;
   assign last_grant = last_q;
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
Arbitrates the register file's single write port between two writeback requesters: ALU result (req 0) and memory-load result (req 1). Uses round-robin priority with a per-requester req/ack handshake. Drives a registered write address, data and enable to the register file's write-port address decoder. Honours a stall from the register file side.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 3, register index width (8 registers)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
alu_req  in  1  ALU requests a register write
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU write data
alu_ack  out  1  one-cycle grant pulse to ALU
mem_req  in  1  load unit requests a register write
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load write data
mem_ack  out  1  one-cycle grant pulse to load unit
rf_stall  in  1  register file cannot accept a write this cycle
rf_wr_en  out  1  write enable to decoder/register file (registered)
rf_wr_addr  out  ADDR_W  write register index (registered)
rf_wr_data  out  DATA_W  write data (registered)
last_grant  out  1  0 = ALU won most recent grant, 1 = load unit

Behaviour:
- Reset (async, reset=1): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, alu_ack=0, mem_ack=0, last_grant=1, so the ALU has first priority after reset.
- Requester rule: req, addr and data are held stable from assertion until the cycle the matching ack is 1. Requester samples ack at the clock edge and may present a new request the following cycle.
- can_grant = !rf_wr_en || !rf_stall. The output slot is empty or retires this cycle.
- Grant (combinational ack, same cycle as request):
  - if can_grant and exactly one req: that requester wins.
  - if both req: winner = requester NOT equal to last_grant.
  - if !can_grant: no ack.
- On the clock edge with a grant: rf_wr_addr/rf_wr_data <= winner's addr/data; rf_wr_en <= 1; last_grant <= winner.
- On the edge with no grant and (rf_wr_en && !rf_stall): rf_wr_en <= 0; addr/data hold.
- On the edge with rf_wr_en && rf_stall: all outputs hold. A stalled write remains presented unchanged.
- Latency: request to rf_wr_en = 1 cycle when unstalled. Throughput is one write per cycle; back-to-back grants keep rf_wr_en high continuously.
- States are implicit, as the output slot is EMPTY (rf_wr_en=0) or FULL (rf_wr_en=1):
  - EMPTY->FULL on grant
  - FULL->FULL on stall, or on grant with !rf_stall
  - FULL->EMPTY on !rf_stall with no grant
- Fairness: with both reqs continuously high, grants alternate every cycle. A requester waits at most 1 grant.
- Reset mid-operation: a pending write is dropped and no ack is issued in the reset cycle. Requesters must re-issue.
- last_grant changes only on a grant.

Optional Feature:
Macro REG_WR_ARB_R0_DISCARD_EN.
- Defined: a granted request with addr=0 is acked normally and last_grant updates, but the slot is not loaded. rf_wr_en is not asserted for it, so R0 is never written.
- Undefined: addr=0 is treated like any other register.

Decomposition:
- Package reg_arb_pkg: DATA_W and ADDR_W constants, plus requester index constants REQ_ALU=0 and REQ_MEM=1.
- One natural sub-module: rr_arb2, the combinational 2-way round-robin grant from (req[1:0], last_grant, can_grant) to one-hot gnt[1:0].
- The top level holds the output slot and the last_grant register.

Test Plan:
- Reset, then alu_req=1, addr=3, data=16'hBEEF, rf_stall=0 -> alu_ack=1 in the same cycle. Next cycle rf_wr_en=1, rf_wr_addr=3, rf_wr_data=16'hBEEF. Cycle after, rf_wr_en=0.
- Both reqs held 4 cycles (ALU addr 1/data 16'h0011, load addr 2/data 16'h0022), rf_stall=0 -> acks in order ALU, MEM, ALU, MEM; rf_wr_addr sequence 1,2,1,2; rf_wr_en high 4 consecutive cycles.
- Slot full with addr=5, rf_stall=1 for 3 cycles while mem_req=1 -> mem_ack=0 throughout and outputs frozen at addr 5. When rf_stall drops: mem_ack=1 that cycle, next cycle rf_wr_addr=mem_addr.
- Assert reset for 1 cycle while rf_wr_en=1 and both reqs high -> outputs reach reset values immediately, no ack. After release, the ALU is granted first.
- With REG_WR_ARB_R0_DISCARD_EN defined, mem_req with addr=0 -> mem_ack=1 and rf_wr_en stays 0. Without the macro, rf_wr_en=1 and rf_wr_addr=0.
- mem_req alone for 2 cycles, then alu_req and mem_req together -> ALU wins, since last_grant=1.
